systolic_array_ctrl: RTL and testbench

SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

---
 rtl/tpu_pkg.sv | 18 +
 rtl/systolic_array_ctrl.sv | 162 ++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU control slice: controller state encoding
// and the pipeline flush length of an N x N systolic array.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COMPUTE = 3'd2,
        FLUSH   = 3'd3,
        DRAIN   = 3'd4
    } ctrl_state_e;

    // The last operand needs 2*(N-1) hops to reach the far PE, plus one MAC cycle.
    function automatic int flush_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer for an ARRAY_N x ARRAY_N systolic array: clear, feed k_len
// operand columns, flush the skew, then drain result rows with a handshake.
// Define SYS_CTRL_PERF_EN to add saturating busy/stall performance counters.
module systolic_array_ctrl
    import tpu_pkg::*;
#(
    parameter int ARRAY_N = 4,
    parameter int KLEN_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KLEN_W-1:0]          k_len,
    input  logic                       operand_valid,
    input  logic                       result_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       clear_acc,
    output logic                       array_en,
    output logic                       feed_valid,
    output logic [KLEN_W-1:0]          feed_idx,
    output logic                       result_valid,
    output logic [$clog2(ARRAY_N)-1:0] result_row
`ifdef SYS_CTRL_PERF_EN
    ,
    output logic [31:0]                perf_busy_cycles,
    output logic [31:0]                perf_stall_cycles
`endif
);

    localparam int ROW_W     = $clog2(ARRAY_N);
    localparam int FLUSH_LEN = flush_len(ARRAY_N);
    localparam int FCNT_W    = $clog2(FLUSH_LEN + 1);

    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ARRAY_N - 1);
    localparam logic [FCNT_W-1:0] LAST_FLUSH = FCNT_W'(FLUSH_LEN - 1);

    ctrl_state_e        state_reg,     state_next;
    logic [KLEN_W-1:0]  k_len_reg,     k_len_next;
    logic [KLEN_W-1:0]  feed_idx_reg,  feed_idx_next;
    logic [FCNT_W-1:0]  flush_cnt_reg, flush_cnt_next;
    logic [ROW_W-1:0]   row_reg,       row_next;
    logic               err_reg,       err_next;

    always_comb begin
        state_next     = state_reg;
        k_len_next     = k_len_reg;
        feed_idx_next  = feed_idx_reg;
        flush_cnt_next = flush_cnt_reg;
        row_next       = row_reg;
        err_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (k_len == '0) begin
                        err_next = 1'b1;
                    end else begin
                        k_len_next = k_len;
                        state_next = CLEAR;
                    end
                end
            end

            CLEAR: begin
                feed_idx_next = '0;
                state_next    = COMPUTE;
            end

            COMPUTE: begin
                if (operand_valid) begin
                    if (feed_idx_reg == k_len_reg - KLEN_W'(1)) begin
                        feed_idx_next  = '0;
                        flush_cnt_next = '0;
                        state_next     = FLUSH;
                    end else begin
                        feed_idx_next = feed_idx_reg + KLEN_W'(1);
                    end
                end
            end

            FLUSH: begin
                if (flush_cnt_reg == LAST_FLUSH) begin
                    flush_cnt_next = '0;
                    row_next       = '0;
                    state_next     = DRAIN;
                end else begin
                    flush_cnt_next = flush_cnt_reg + FCNT_W'(1);
                end
            end

            DRAIN: begin
                if (result_ready) begin
                    if (row_reg == LAST_ROW) begin
                        row_next   = '0;
                        state_next = IDLE;
                    end else begin
                        row_next = row_reg + ROW_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            k_len_reg     <= '0;
            feed_idx_reg  <= '0;
            flush_cnt_reg <= '0;
            row_reg       <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            k_len_reg     <= k_len_next;
            feed_idx_reg  <= feed_idx_next;
            flush_cnt_reg <= flush_cnt_next;
            row_reg       <= row_next;
            err_reg       <= err_next;
        end
    end

    // PEs and skew buffers stall together in the very cycle operand_valid drops,
    // so no operand column is lost or duplicated across a stall.
    assign busy         = (state_reg != IDLE);
    assign clear_acc    = (state_reg == CLEAR);
    assign feed_valid   = (state_reg == COMPUTE) && operand_valid;
    assign array_en     = (state_reg == CLEAR) || (state_reg == FLUSH) || feed_valid;
    assign feed_idx     = feed_idx_reg;
    assign result_valid = (state_reg == DRAIN);
    assign result_row   = row_reg;
    assign done         = (state_reg == DRAIN) && result_ready && (row_reg == LAST_ROW);
    assign err          = err_reg;

`ifdef SYS_CTRL_PERF_EN
    logic [31:0] perf_busy_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (busy && (perf_busy_reg != '1)) begin
                perf_busy_reg <= perf_busy_reg + 32'd1;
            end
            if ((state_reg == COMPUTE) && !operand_valid && (perf_stall_reg != '1)) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_busy_cycles  = perf_busy_reg;
    assign perf_stall_cycles = perf_stall_reg;
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl (ARRAY_N=4): nominal tile, stalls,
// drain back-pressure, rejected start, ignored starts and mid-flush reset.
module tb_systolic_array_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] k_len = '0;
    logic       operand_valid = 1'b0;
    logic       result_ready = 1'b0;
    logic       busy, done, err, clear_acc, array_en, feed_valid, result_valid;
    logic [7:0] feed_idx;
    logic [1:0] result_row;
`ifdef SYS_CTRL_PERF_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // {busy, done, err, clear_acc, array_en, feed_valid, result_valid}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_ERR   = 7'b0010000;
    localparam logic [6:0] O_CLEAR = 7'b1001100;
    localparam logic [6:0] O_FEED  = 7'b1000110;
    localparam logic [6:0] O_STALL = 7'b1000000;
    localparam logic [6:0] O_FLUSH = 7'b1000100;
    localparam logic [6:0] O_DRAIN = 7'b1000001;
    localparam logic [6:0] O_DONE  = 7'b1100001;

    systolic_array_ctrl #(.ARRAY_N(4), .KLEN_W(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .k_len             (k_len),
        .operand_valid     (operand_valid),
        .result_ready      (result_ready),
        .busy              (busy),
        .done              (done),
        .err               (err),
        .clear_acc         (clear_acc),
        .array_en          (array_en),
        .feed_valid        (feed_valid),
        .feed_idx          (feed_idx),
        .result_valid      (result_valid),
        .result_row        (result_row)
`ifdef SYS_CTRL_PERF_EN
        ,
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [6:0] exp_ctl,
                             input int exp_idx, input int exp_row);
        check({tag, ".ctl"}, {busy, done, err, clear_acc, array_en, feed_valid, result_valid}, exp_ctl);
        check({tag, ".idx"}, feed_idx, exp_idx);
        check({tag, ".row"}, result_row, exp_row);
        $display("%0t %s ctl=%b idx=%0d row=%0d", $time, tag,
                 {busy, done, err, clear_acc, array_en, feed_valid, result_valid}, feed_idx, result_row);
    endtask

    // Drive one cycle's inputs after the falling edge, then let outputs settle.
    task automatic cyc(input logic s, input logic [7:0] k, input logic ov, input logic rr);
        @(negedge clk);
        start = s;
        k_len = k;
        operand_valid = ov;
        result_ready = rr;
        #1;
    endtask

    // 7 flush cycles, 4 drain rows with ready held high, then idle.
    // A start in the done cycle must be ignored.
    task automatic flush_drain(input string tag);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 8'd0, 1'b1, 1'b1);
            check_out($sformatf("%s.flush%0d", tag, i), O_FLUSH, 0, 0);
        end
        for (int r = 0; r < 4; r++) begin
            if (r == 3) cyc(1'b1, 8'd2, 1'b1, 1'b1);
            else        cyc(1'b0, 8'd0, 1'b1, 1'b1);
            check_out($sformatf("%s.drain%0d", tag, r), (r == 3) ? O_DONE : O_DRAIN, 0, r);
        end
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out({tag, ".idle"}, O_IDLE, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_out("reset", O_IDLE, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal tile, k_len=3: done in cycle 15 after start
        cyc(1'b1, 8'd3, 1'b1, 1'b1);
        check_out("t1.start", O_IDLE, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t1.clear", O_CLEAR, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'd0, 1'b1, 1'b1);
            check_out($sformatf("t1.feed%0d", i), O_FEED, i, 0);
        end
        flush_drain("t1");

        // k_len=0 rejected: err one cycle later, never busy
        cyc(1'b1, 8'd0, 1'b1, 1'b1);
        check_out("t3.start", O_IDLE, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t3.err", O_ERR, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t3.after", O_IDLE, 0, 0);

        // k_len=5 with a 2-cycle stall at idx 2, start mid-COMPUTE, drain back-pressure
        cyc(1'b1, 8'd5, 1'b1, 1'b1);
        check_out("t2.start", O_IDLE, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t2.clear", O_CLEAR, 0, 0);
        cyc(1'b1, 8'd0, 1'b1, 1'b1);
        check_out("t2.feed0", O_FEED, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t2.feed1", O_FEED, 1, 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check_out("t2.stall0", O_STALL, 2, 0);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check_out("t2.stall1", O_STALL, 2, 0);
        for (int i = 2; i < 5; i++) begin
            cyc(1'b0, 8'd0, 1'b1, 1'b1);
            check_out($sformatf("t2.feed%0d", i), O_FEED, i, 0);
        end
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b1);
            check_out($sformatf("t2.flush%0d", i), O_FLUSH, 0, 0);
        end
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check_out("t2.drain0", O_DRAIN, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'd0, 1'b0, 1'b0);
            check_out($sformatf("t2.hold%0d", i), O_DRAIN, 0, 1);
        end
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check_out("t2.drain1", O_DRAIN, 0, 1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check_out("t2.drain2", O_DRAIN, 0, 2);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check_out("t2.drain3", O_DONE, 0, 3);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        check_out("t2.idle", O_IDLE, 0, 0);
`ifdef SYS_CTRL_PERF_EN
        check("perf.busy", perf_busy_cycles, 37);
        check("perf.stall", perf_stall_cycles, 2);
`endif

        // Reset asserted mid-FLUSH clears outputs at once
        cyc(1'b1, 8'd2, 1'b1, 1'b1);
        check_out("t4.start", O_IDLE, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t4.clear", O_CLEAR, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t4.feed0", O_FEED, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t4.feed1", O_FEED, 1, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t4.flush0", O_FLUSH, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t4.rst", O_IDLE, 0, 0);
`ifdef SYS_CTRL_PERF_EN
        check("perf.rst", perf_busy_cycles, 0);
`endif

        // First cycle after release accepts start; k_len=1 tile completes
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        k_len = 8'd1;
        #1;
        check_out("t5.start", O_IDLE, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t5.clear", O_CLEAR, 0, 0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        check_out("t5.feed0", O_FEED, 0, 0);
        flush_drain("t5");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
